pixel_scheduler: RTL
====================

PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 SHALL have parameters: NUM_CORES, default 4, number of depth-calculator cores; WORD_LENGTH, default 32, fixed-point word width; FRAC, default 28, fractional bits.
REQ-002 SHALL have ports:
- sysclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle request to render a frame.
- width, height  in  11 each  frame size in pixels.
- re_origin, im_origin  in  WORD_LENGTH, signed  c at pixel (0,0).
- step  in  WORD_LENGTH, signed  c increment per pixel.
- core_start  out  NUM_CORES  per-core start pulse.
- core_x, core_y  out  NUM_CORES*11  per-core pixel coordinates.
- core_re_c, core_im_c  out  NUM_CORES*WORD_LENGTH  per-core c.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- core_depth  in  NUM_CORES*11  per-core result, valid with core_done.
- pix_valid  out  1  result available.
- pix_ready  in  1  downstream accepts.
- pix_x, pix_y, pix_depth  out  11 each  result tag and depth.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when the last pixel is accepted.

Function
REQ-003 SHALL use FSM states IDLE, DISPATCH, DRAIN, DONE.
REQ-004 IDLE: on frame_start, latch width, height, re_origin, im_origin and step, set x=y=0, set re_cur=re_origin and im_cur=im_origin, and go to DISPATCH. If width or height is 0, go to DONE instead.
REQ-005 frame_start outside IDLE SHALL be ignored; latched configuration SHALL NOT change mid-frame.
REQ-006 A core is free when it is not busy and its result slot is empty.
REQ-007 DISPATCH: each cycle, at most one dispatch, to the lowest-index free core. The dispatch:
- loads that core's x, y, re_c, im_c registers;
- pulses its core_start for exactly one cycle;
- sets its busy flag.
REQ-008 Coordinate advance after each dispatch:
- x+1 and re_cur+step.
- At x==width-1: x=0, re_cur=re_origin, y+1, im_cur-step (imaginary decreases downward).
- Arithmetic SHALL be wrapping two's-complement, WORD_LENGTH bits, with no multiplier.
REQ-009 After dispatching pixel (width-1, height-1), SHALL go to DRAIN.
REQ-010 Per-core registers SHALL hold stable from dispatch until the next dispatch to that core.
REQ-011 On core_done[i], SHALL capture core_depth[i], x and y into slot i, mark slot full and clear busy[i], in the same cycle as the pulse.
REQ-012 Capture SHALL never be dropped; REQ-006 guarantees the slot is empty.
REQ-013 Output: slots are arbitrated round-robin among full slots.
- pix_valid is high when any slot is full.
- pix_x, pix_y and pix_depth come from the granted slot and are held stable until pix_valid && pix_ready.
- On handshake, the slot is emptied and priority moves to grant+1.
- The grant SHALL NOT change while pix_valid is high and pix_ready is low.
REQ-014 Output order is not raster order; pix_x/pix_y tag each result.
REQ-015 Capture into slot i and drain of slot j SHALL both take effect in the same cycle. A slot drained in cycle t SHALL be free for dispatch in cycle t+1.
REQ-016 DRAIN: when no core is busy and no slot is full, go to DONE.
REQ-017 DONE: pulse frame_done for one cycle, then go to IDLE.
REQ-018 busy SHALL be high in DISPATCH and DRAIN, low in IDLE and DONE.
REQ-019 Exactly width*height results SHALL be emitted per frame.
REQ-020 Output timing: minimum one cycle from core_done to pix_valid (registered slot); zero cycles from pix_ready to slot release.

Reset
REQ-021 Reset SHALL force, asynchronously:
- FSM to IDLE;
- core_start, pix_valid, busy and frame_done to 0;
- all busy flags, slot-full flags and x/y counters to 0;
- round-robin pointer to 0;
- core_x/core_y/core_re_c/core_im_c and pix_x/pix_y/pix_depth to 0.
REQ-022 Reset mid-frame SHALL discard all in-flight results. No core_start SHALL issue until a new frame_start after release.

Structure
REQ-023 A shared package mandel_pkg SHALL hold:
- the scheduler state enum;
- WORD_LENGTH and FRAC defaults;
- coordinate width 11;
- depth width 11.
REQ-024 The round-robin selector SHALL be a separate sub-module rr_arbiter (NUM_CORES requests, one-hot grant, advance-on-accept).

Verification
REQ-025 2x2 frame, NUM_CORES=4, each core done 5 cycles after start, pix_ready=1 -> 4 starts on consecutive cycles; 4 results tagged (0,0),(1,0),(0,1),(1,1); one frame_done.
REQ-026 re_origin=-2.0, im_origin=1.0, step=0.25 (Q4.28), width=3 -> core_re_c -2.0,-1.75,-1.5, then -2.0 with im_c=0.75 on the second row.
REQ-027 pix_ready=0 for 20 cycles with all slots full -> no core_start issued, pix_* held stable; after release, dispatch resumes one cycle after each accept.
REQ-028 core_done on cores 1 and 3 in the same cycle that slot 0 drains -> both captured, grant order 1 then 3, nothing lost.
REQ-029 width=0 -> frame_done two cycles after frame_start; no core_start.
REQ-030 Reset asserted mid-DISPATCH with 2 cores busy -> all outputs 0 immediately; late core_done pulses after release ignored; new 1x1 frame completes correctly.

Source files
------------

// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// mandel_pkg
// Shared widths, defaults and scheduler state encoding for the Mandelbrot
// pixel pipeline.
// Revision: 1.0
// ============================================================================
package mandel_pkg;

  localparam int WORD_LENGTH_DEF = 32;
  localparam int FRAC_DEF        = 28;
  localparam int COORD_W         = 11;
  localparam int DEPTH_W         = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter
// Round-robin selector with one-hot grant; priority moves past the winner
// only on accept, and the grant is frozen while a request waits unaccepted.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_accept,
  output logic [N-1:0] o_grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0]  r_ptr;
  logic [IW-1:0]  r_hold_idx;
  logic           r_hold;
  logic [2*N-1:0] w_req2;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;
  logic [IW-1:0]  w_rr_idx;
  logic [IW-1:0]  w_sel_idx;
  logic           w_any;

  // Rotate the request vector so bit 0 is the current priority holder.
  always_comb begin
    w_any  = |i_req;
    w_req2 = {i_req, i_req} >> r_ptr;
    w_off  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_req2[k]) w_off = IW'(k);
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_rr_idx  = (w_sum >= (IW + 1)'(N)) ? IW'(w_sum - (IW + 1)'(N)) : IW'(w_sum);
    w_sel_idx = r_hold ? r_hold_idx : w_rr_idx;
    o_grant   = w_any ? (N'(1) << w_sel_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
    end else if (i_accept) begin
      r_ptr  <= (w_sel_idx == IW'(N - 1)) ? '0 : w_sel_idx + IW'(1);
      r_hold <= 1'b0;
    end else begin
      r_hold     <= w_any;
      r_hold_idx <= w_sel_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_scheduler.sv
`default_nettype none
// ============================================================================
// pixel_scheduler
// Walks a frame in raster order, hands pixels to free depth cores, and
// returns tagged results through a round-robin output port.
// Revision: 1.0
// ============================================================================
module pixel_scheduler
  import mandel_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int FRAC        = FRAC_DEF
) (
  input  logic                             sysclk,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic [COORD_W-1:0]               width,
  input  logic [COORD_W-1:0]               height,
  input  logic signed [WORD_LENGTH-1:0]    re_origin,
  input  logic signed [WORD_LENGTH-1:0]    im_origin,
  input  logic signed [WORD_LENGTH-1:0]    step,
  output logic [NUM_CORES-1:0]             core_start,
  output logic [NUM_CORES*COORD_W-1:0]     core_x,
  output logic [NUM_CORES*COORD_W-1:0]     core_y,
  output logic [NUM_CORES*WORD_LENGTH-1:0] core_re_c,
  output logic [NUM_CORES*WORD_LENGTH-1:0] core_im_c,
  input  logic [NUM_CORES-1:0]             core_done,
  input  logic [NUM_CORES*DEPTH_W-1:0]     core_depth,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [COORD_W-1:0]               pix_x,
  output logic [COORD_W-1:0]               pix_y,
  output logic [DEPTH_W-1:0]               pix_depth,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int CW = COORD_W;
  localparam int DW = DEPTH_W;
  localparam int WL = WORD_LENGTH;
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  if (FRAC >= WORD_LENGTH) begin : g_frac_check
    $error("FRAC must be smaller than WORD_LENGTH");
  end

  sched_state_t         r_state;
  logic [CW-1:0]        r_width, r_height, r_x, r_y;
  logic signed [WL-1:0] r_re_origin, r_step, r_re_cur, r_im_cur;
  logic                 r_frame_done;

  logic [NUM_CORES-1:0] r_core_start, r_core_busy, r_slot_full;
  logic [CW-1:0]        r_core_x [NUM_CORES];
  logic [CW-1:0]        r_core_y [NUM_CORES];
  logic signed [WL-1:0] r_core_re [NUM_CORES];
  logic signed [WL-1:0] r_core_im [NUM_CORES];
  logic [CW-1:0]        r_slot_x [NUM_CORES];
  logic [CW-1:0]        r_slot_y [NUM_CORES];
  logic [DW-1:0]        r_slot_d [NUM_CORES];

  logic [NUM_CORES-1:0] w_free, w_grant;
  logic [DW-1:0]        w_done_depth [NUM_CORES];
  logic [IW-1:0]        w_disp_idx;
  logic                 w_disp_ok, w_dispatch, w_row_end, w_last, w_accept;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign core_x[g*CW +: CW]    = r_core_x[g];
    assign core_y[g*CW +: CW]    = r_core_y[g];
    assign core_re_c[g*WL +: WL] = r_core_re[g];
    assign core_im_c[g*WL +: WL] = r_core_im[g];
    assign w_done_depth[g]       = core_depth[g*DW +: DW];
  end

  assign core_start = r_core_start;
  assign frame_done = r_frame_done;
  assign busy       = (r_state == ST_DISPATCH) || (r_state == ST_DRAIN);
  assign pix_valid  = |r_slot_full;
  assign w_accept   = pix_valid && pix_ready;
  assign w_row_end  = (r_x == r_width - CW'(1));
  assign w_last     = w_row_end && (r_y == r_height - CW'(1));

  // A core is only reusable once its previous result has left the slot.
  always_comb begin
    w_free     = ~r_core_busy & ~r_slot_full;
    w_disp_ok  = 1'b0;
    w_disp_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_disp_ok  = 1'b1;
        w_disp_idx = IW'(i);
      end
    end
    w_dispatch = (r_state == ST_DISPATCH) && w_disp_ok;
  end

  always_comb begin
    pix_x     = '0;
    pix_y     = '0;
    pix_depth = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_grant[i]) begin
        pix_x     = r_slot_x[i];
        pix_y     = r_slot_y[i];
        pix_depth = r_slot_d[i];
      end
    end
  end

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_rr_arbiter (
    .clk      (sysclk),
    .rst      (reset),
    .i_req    (r_slot_full),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_re_origin  <= '0;
      r_step       <= '0;
      r_re_cur     <= '0;
      r_im_cur     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_width     <= width;
            r_height    <= height;
            r_re_origin <= re_origin;
            r_step      <= step;
            r_re_cur    <= re_origin;
            r_im_cur    <= im_origin;
            r_x         <= '0;
            r_y         <= '0;
            r_state     <= (width == '0 || height == '0) ? ST_DONE : ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (w_dispatch) begin
            if (w_row_end) begin
              r_x      <= '0;
              r_y      <= r_y + CW'(1);
              r_re_cur <= r_re_origin;
              r_im_cur <= r_im_cur - r_step;
              if (w_last) r_state <= ST_DRAIN;
            end else begin
              r_x      <= r_x + CW'(1);
              r_re_cur <= r_re_cur + r_step;
            end
          end
        end
        ST_DRAIN: begin
          if (!(|r_core_busy) && !(|r_slot_full)) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Completion is gated by busy so stray pulses after a reset are dropped.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_core_start <= '0;
      r_core_busy  <= '0;
      r_slot_full  <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_core_x[i]  <= '0;
        r_core_y[i]  <= '0;
        r_core_re[i] <= '0;
        r_core_im[i] <= '0;
        r_slot_x[i]  <= '0;
        r_slot_y[i]  <= '0;
        r_slot_d[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_core_start[i] <= w_dispatch && (w_disp_idx == IW'(i));
        if (w_accept && w_grant[i]) r_slot_full[i] <= 1'b0;
        if (w_dispatch && (w_disp_idx == IW'(i))) begin
          r_core_x[i]    <= r_x;
          r_core_y[i]    <= r_y;
          r_core_re[i]   <= r_re_cur;
          r_core_im[i]   <= r_im_cur;
          r_core_busy[i] <= 1'b1;
        end else if (core_done[i] && r_core_busy[i]) begin
          r_core_busy[i] <= 1'b0;
          r_slot_full[i] <= 1'b1;
          r_slot_x[i]    <= r_core_x[i];
          r_slot_y[i]    <= r_core_y[i];
          r_slot_d[i]    <= w_done_depth[i];
        end
      end
    end
  end

endmodule
`default_nettype wire
